// File: rtl/trace_store_ctrl.sv
// Trace/stream buffer controller answering the tracer's store/load handshake.
// Optional stream-mode FIFO is compiled in when TRB_STREAM_EN is defined.
module trace_store_ctrl #(
  parameter int unsigned TRB_WIDTH = 32,
  parameter int unsigned TRB_DEPTH = 64,
  localparam int unsigned AW = $clog2(TRB_DEPTH)
) (
  input  logic                 FPGA_CLK_I,
  input  logic                 RST_I,
  input  logic                 EN_I,
  input  logic                 MODE_I,
  input  logic [AW-1:0]        TRG_DELAY_I,
  input  logic                 TRG_EVENT_I,
  input  logic                 STORE_I,
  input  logic [TRB_WIDTH-1:0] DATA_I,
  input  logic                 LOAD_I,
  output logic [TRB_WIDTH-1:0] DATA_O,
  output logic                 LOAD_O,
  output logic                 TRG_EVENT_O,
  output logic                 DONE_O,
  output logic                 WRAP_O,
  output logic [AW-1:0]        TRG_ADDR_O,
  output logic [AW-1:0]        WR_PTR_O,
  input  logic                 HOST_WE_I,
  input  logic [TRB_WIDTH-1:0] HOST_WDATA_I,
  output logic                 HOST_FULL_O,
  input  logic                 HOST_RE_I,
  input  logic [AW-1:0]        HOST_ADDR_I,
  output logic [TRB_WIDTH-1:0] HOST_RDATA_O
);

  typedef enum logic [2:0] {StIdle, StArmed, StPost, StDone, StStream} state_e;

  state_e               state_q, state_d;
  logic [AW-1:0]        wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]        cnt_q, cnt_d;
  logic [AW-1:0]        trg_addr_q, trg_addr_d;
  logic                 wrap_q, wrap_d;
  logic                 done_q, done_d;

  logic [TRB_WIDTH-1:0] mem [TRB_DEPTH];
  logic                 mem_we;
  logic [TRB_WIDTH-1:0] mem_wdata;
  logic [AW-1:0]        mem_raddr;
  logic                 load_req;
  logic                 host_rd_ok;

  logic [TRB_WIDTH-1:0] data_q;
  logic                 load_q;
  logic [TRB_WIDTH-1:0] host_rdata_q;

`ifdef TRB_STREAM_EN
  localparam logic [AW:0] CntFull = (AW+1)'(TRB_DEPTH);

  logic [AW:0]   fifo_cnt_q, fifo_cnt_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic          pending_q, pending_d;
  logic          push_ok, pop_ok;

  assign HOST_FULL_O = (fifo_cnt_q == CntFull);
`else
  logic unused_host;
  assign unused_host = ^{HOST_WE_I, HOST_WDATA_I};
  assign HOST_FULL_O = 1'b0;
`endif

  assign host_rd_ok = (state_q == StIdle) || (state_q == StDone);

  always_comb begin
    state_d    = state_q;
    wr_ptr_d   = wr_ptr_q;
    cnt_d      = cnt_q;
    trg_addr_d = trg_addr_q;
    wrap_d     = wrap_q;
    done_d     = done_q;
    mem_we     = 1'b0;
    mem_wdata  = DATA_I;
    load_req   = 1'b0;
    // Host reads and tracer loads never overlap in state, so they share one read port.
    mem_raddr  = host_rd_ok ? HOST_ADDR_I : wr_ptr_q;
`ifdef TRB_STREAM_EN
    fifo_cnt_d = fifo_cnt_q;
    rd_ptr_d   = rd_ptr_q;
    pending_d  = pending_q;
    push_ok    = 1'b0;
    pop_ok     = 1'b0;
`endif

    if (!EN_I) begin
      state_d = StIdle;
      done_d  = 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (!MODE_I) begin
            state_d    = StArmed;
            wr_ptr_d   = '0;
            wrap_d     = 1'b0;
            done_d     = 1'b0;
            trg_addr_d = '0;
`ifdef TRB_STREAM_EN
            rd_ptr_d   = '0;
          end else begin
            state_d    = StStream;
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            fifo_cnt_d = '0;
            pending_d  = 1'b0;
`endif
          end
        end

        StArmed, StPost: begin
          if (STORE_I) begin
            mem_we   = 1'b1;
            wr_ptr_d = wr_ptr_q + 1'b1;
            if (wr_ptr_q == '1) wrap_d = 1'b1;
          end
          // Reading the slot about to be overwritten yields the oldest word.
          load_req = LOAD_I;
          if (state_q == StArmed) begin
            if (TRG_EVENT_I) begin
              trg_addr_d = wr_ptr_d;
              cnt_d      = TRG_DELAY_I;
              state_d    = StPost;
            end
          end else if (STORE_I) begin
            if (cnt_q == '0) begin
              state_d = StDone;
              done_d  = 1'b1;
            end else begin
              cnt_d = cnt_q - 1'b1;
            end
          end
        end

        StDone: ;

`ifdef TRB_STREAM_EN
        StStream: begin
          push_ok = HOST_WE_I && (fifo_cnt_q != CntFull);
          pop_ok  = (LOAD_I || pending_q) && (fifo_cnt_q != '0);
          if (push_ok) begin
            mem_we    = 1'b1;
            mem_wdata = HOST_WDATA_I;
            wr_ptr_d  = wr_ptr_q + 1'b1;
          end
          if (pop_ok) begin
            load_req  = 1'b1;
            mem_raddr = rd_ptr_q;
            rd_ptr_d  = rd_ptr_q + 1'b1;
            pending_d = 1'b0;
          end else if (LOAD_I) begin
            pending_d = 1'b1;
          end
          unique case ({push_ok, pop_ok})
            2'b10:   fifo_cnt_d = fifo_cnt_q + 1'b1;
            2'b01:   fifo_cnt_d = fifo_cnt_q - 1'b1;
            default: ;
          endcase
        end
`endif

        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge FPGA_CLK_I) begin
    if (RST_I) begin
      state_q      <= StIdle;
      wr_ptr_q     <= '0;
      cnt_q        <= '0;
      trg_addr_q   <= '0;
      wrap_q       <= 1'b0;
      done_q       <= 1'b0;
      data_q       <= '0;
      load_q       <= 1'b0;
      host_rdata_q <= '0;
`ifdef TRB_STREAM_EN
      fifo_cnt_q   <= '0;
      rd_ptr_q     <= '0;
      pending_q    <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      cnt_q      <= cnt_d;
      trg_addr_q <= trg_addr_d;
      wrap_q     <= wrap_d;
      done_q     <= done_d;
      load_q     <= load_req;
      if (load_req) data_q <= mem[mem_raddr];
      if (HOST_RE_I) host_rdata_q <= host_rd_ok ? mem[mem_raddr] : '0;
`ifdef TRB_STREAM_EN
      fifo_cnt_q <= fifo_cnt_d;
      rd_ptr_q   <= rd_ptr_d;
      pending_q  <= pending_d;
`endif
    end
  end

  // Storage is deliberately left out of reset so a capture survives RST_I.
  always_ff @(posedge FPGA_CLK_I) begin
    if (mem_we) mem[wr_ptr_q] <= mem_wdata;
  end

  assign DATA_O       = data_q;
  assign LOAD_O       = load_q;
  assign TRG_EVENT_O  = done_q;
  assign DONE_O       = done_q;
  assign WRAP_O       = wrap_q;
  assign TRG_ADDR_O   = trg_addr_q;
  assign WR_PTR_O     = wr_ptr_q;
  assign HOST_RDATA_O = host_rdata_q;

endmodule

// File: tb/tb_trace_store_ctrl.sv
// Scoreboard bench for trace_store_ctrl; stream checks compile in with TRB_STREAM_EN.
module tb_trace_store_ctrl;
  localparam int W  = 32;
  localparam int D  = 64;
  localparam int AW = 6;

  logic          clk = 1'b0;
  logic          RST_I = 1'b1, EN_I = 1'b0, MODE_I = 1'b0;
  logic [AW-1:0] TRG_DELAY_I = '0;
  logic          TRG_EVENT_I = 1'b0, STORE_I = 1'b0, LOAD_I = 1'b0;
  logic [W-1:0]  DATA_I = '0;
  logic [W-1:0]  DATA_O;
  logic          LOAD_O, TRG_EVENT_O, DONE_O, WRAP_O;
  logic [AW-1:0] TRG_ADDR_O, WR_PTR_O;
  logic          HOST_WE_I = 1'b0;
  logic [W-1:0]  HOST_WDATA_I = '0;
  logic          HOST_FULL_O;
  logic          HOST_RE_I = 1'b0;
  logic [AW-1:0] HOST_ADDR_I = '0;
  logic [W-1:0]  HOST_RDATA_O;

  trace_store_ctrl #(.TRB_WIDTH(W), .TRB_DEPTH(D)) dut (
    .FPGA_CLK_I(clk), .RST_I(RST_I), .EN_I(EN_I), .MODE_I(MODE_I),
    .TRG_DELAY_I(TRG_DELAY_I), .TRG_EVENT_I(TRG_EVENT_I), .STORE_I(STORE_I),
    .DATA_I(DATA_I), .LOAD_I(LOAD_I), .DATA_O(DATA_O), .LOAD_O(LOAD_O),
    .TRG_EVENT_O(TRG_EVENT_O), .DONE_O(DONE_O), .WRAP_O(WRAP_O),
    .TRG_ADDR_O(TRG_ADDR_O), .WR_PTR_O(WR_PTR_O), .HOST_WE_I(HOST_WE_I),
    .HOST_WDATA_I(HOST_WDATA_I), .HOST_FULL_O(HOST_FULL_O), .HOST_RE_I(HOST_RE_I),
    .HOST_ADDR_I(HOST_ADDR_I), .HOST_RDATA_O(HOST_RDATA_O)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [W-1:0] data;
    int           due;
  } exp_t;
  exp_t         exp_q[$];
  logic [W-1:0] sq[$];
  logic [W-1:0] mdl [D];
  int           wp = 0;

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (LOAD_O === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("load_unexpected", {31'd0, LOAD_O}, '0);
      end else begin
        e = exp_q.pop_front();
        check("load_data", DATA_O, e.data);
        check("load_cycle", cyc, e.due);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic trace_store(input logic [W-1:0] d, input bit ld);
    exp_t e;
    STORE_I = 1'b1;
    DATA_I  = d;
    LOAD_I  = ld;
    if (ld) begin
      e.data = mdl[wp];
      e.due  = cyc + 1;
      exp_q.push_back(e);
    end
    mdl[wp] = d;
    wp = (wp + 1) % D;
    tick();
    STORE_I = 1'b0;
    LOAD_I  = 1'b0;
  endtask

  task automatic arm();
    EN_I   = 1'b1;
    MODE_I = 1'b0;
    tick();
    wp = 0;
  endtask

  task automatic disarm();
    EN_I = 1'b0;
    tick();
  endtask

  task automatic host_rd(input logic [AW-1:0] a, input logic [W-1:0] exp, input string tag);
    HOST_RE_I   = 1'b1;
    HOST_ADDR_I = a;
    tick();
    HOST_RE_I = 1'b0;
    check(tag, HOST_RDATA_O, exp);
  endtask

  task automatic s_cycle(input bit we, input logic [W-1:0] d, input bit ld);
    exp_t e;
    bit   full;
    full         = (sq.size() == D);
    HOST_WE_I    = we;
    HOST_WDATA_I = d;
    LOAD_I       = ld;
    if (ld && sq.size() > 0) begin
      e.data = sq.pop_front();
      e.due  = cyc + 1;
      exp_q.push_back(e);
    end
    if (we && !full) sq.push_back(d);
    tick();
    HOST_WE_I = 1'b0;
    LOAD_I    = 1'b0;
  endtask

  initial begin
    exp_t e;
    repeat (3) tick();
    check("rst_data_o", DATA_O, '0);
    check("rst_load_o", {31'd0, LOAD_O}, '0);
    check("rst_trg_event_o", {31'd0, TRG_EVENT_O}, '0);
    check("rst_done_o", {31'd0, DONE_O}, '0);
    check("rst_wrap_o", {31'd0, WRAP_O}, '0);
    check("rst_trg_addr_o", {26'd0, TRG_ADDR_O}, '0);
    check("rst_wr_ptr_o", {26'd0, WR_PTR_O}, '0);
    check("rst_host_full_o", {31'd0, HOST_FULL_O}, '0);
    check("rst_host_rdata_o", HOST_RDATA_O, '0);
    RST_I = 1'b0;
    tick();

    // Ring wrap with delay-line loads on the last stores.
    arm();
    for (int i = 0; i < 70; i++) trace_store(W'(i), i >= 64);
    check("wrap_set", {31'd0, WRAP_O}, 32'd1);
    check("wr_ptr_70", {26'd0, WR_PTR_O}, 32'd6);
    host_rd(6'd5, '0, "host_rd_armed_zero");
    disarm();
    host_rd(6'd5, 32'd69, "host_rd_addr5");
    host_rd(6'd6, 32'd6, "host_rd_addr6");

    // Read-first on same-address store/load.
    arm();
    check("rearm_wr_ptr", {26'd0, WR_PTR_O}, '0);
    check("rearm_wrap", {31'd0, WRAP_O}, '0);
    trace_store(32'hA5, 1'b0);
    disarm();
    arm();
    trace_store(32'h5A, 1'b1);
    disarm();
    host_rd(6'd0, 32'h5A, "host_rd_new_word");

    // Trigger without coincident store, delay 3.
    arm();
    for (int i = 0; i < 10; i++) trace_store(32'h100 + W'(i), 1'b0);
    TRG_DELAY_I = 6'd3;
    TRG_EVENT_I = 1'b1;
    tick();
    check("trg_addr_10", {26'd0, TRG_ADDR_O}, 32'd10);
    for (int i = 0; i < 3; i++) begin
      trace_store(32'h200 + W'(i), 1'b0);
      check("done_early", {31'd0, DONE_O}, '0);
    end
    trace_store(32'h203, 1'b0);
    check("done_rise", {31'd0, DONE_O}, 32'd1);
    check("trg_event_rise", {31'd0, TRG_EVENT_O}, 32'd1);
    check("wr_ptr_14", {26'd0, WR_PTR_O}, 32'd14);
    STORE_I = 1'b1;
    DATA_I  = 32'hDEAD;
    LOAD_I  = 1'b1;
    tick();
    STORE_I = 1'b0;
    LOAD_I  = 1'b0;
    check("done_store_ignored", {26'd0, WR_PTR_O}, 32'd14);
    host_rd(6'd13, 32'h203, "host_rd_done_13");
    host_rd(6'd14, 32'd14, "host_rd_done_14");
    TRG_EVENT_I = 1'b0;
    disarm();

    // Trigger coincident with a store.
    arm();
    for (int i = 0; i < 10; i++) trace_store(32'h300 + W'(i), 1'b0);
    TRG_DELAY_I = 6'd0;
    TRG_EVENT_I = 1'b1;
    trace_store(32'h30A, 1'b0);
    check("trg_addr_11", {26'd0, TRG_ADDR_O}, 32'd11);
    check("done_not_yet", {31'd0, DONE_O}, '0);
    trace_store(32'h30B, 1'b0);
    check("done_delay0", {31'd0, DONE_O}, 32'd1);
    check("wr_ptr_12", {26'd0, WR_PTR_O}, 32'd12);
    TRG_EVENT_I = 1'b0;
    disarm();

    // Reset in the middle of POST.
    arm();
    TRG_DELAY_I = 6'd5;
    TRG_EVENT_I = 1'b1;
    tick();
    trace_store(32'h77, 1'b0);
    trace_store(32'h88, 1'b1);
    RST_I = 1'b1;
    tick();
    RST_I       = 1'b0;
    TRG_EVENT_I = 1'b0;
    EN_I        = 1'b0;
    check("midrst_done", {31'd0, DONE_O}, '0);
    check("midrst_trg_event", {31'd0, TRG_EVENT_O}, '0);
    check("midrst_wr_ptr", {26'd0, WR_PTR_O}, '0);
    check("midrst_trg_addr", {26'd0, TRG_ADDR_O}, '0);
    check("midrst_load_o", {31'd0, LOAD_O}, '0);
    check("midrst_data_o", DATA_O, '0);
    tick();
    host_rd(6'd1, 32'h88, "host_rd_after_rst");

`ifdef TRB_STREAM_EN
    EN_I   = 1'b1;
    MODE_I = 1'b1;
    tick();
    // Load on empty FIFO, push three cycles later.
    LOAD_I = 1'b1;
    tick();
    LOAD_I = 1'b0;
    tick();
    tick();
    e.data = 32'h1234;
    e.due  = cyc + 2;
    exp_q.push_back(e);
    HOST_WE_I    = 1'b1;
    HOST_WDATA_I = 32'h1234;
    tick();
    HOST_WE_I = 1'b0;
    repeat (3) tick();
    check("stream_not_full", {31'd0, HOST_FULL_O}, '0);
    for (int i = 0; i < 64; i++) s_cycle(1'b1, 32'h400 + W'(i), 1'b0);
    check("stream_full_64", {31'd0, HOST_FULL_O}, 32'd1);
    s_cycle(1'b1, 32'hBAD, 1'b0);
    check("stream_full_65", {31'd0, HOST_FULL_O}, 32'd1);
    s_cycle(1'b1, 32'hBAD2, 1'b1);
    check("stream_full_drop", {31'd0, HOST_FULL_O}, '0);
    for (int i = 0; i < 63; i++) s_cycle(1'b0, '0, 1'b1);
    s_cycle(1'b1, 32'hAAAA, 1'b0);
    s_cycle(1'b1, 32'hBBBB, 1'b1);
    s_cycle(1'b0, '0, 1'b1);
    tick();
    // Second load while pending is absorbed.
    LOAD_I = 1'b1;
    tick();
    tick();
    LOAD_I = 1'b0;
    e.data = 32'hCCCC;
    e.due  = cyc + 2;
    exp_q.push_back(e);
    HOST_WE_I    = 1'b1;
    HOST_WDATA_I = 32'hCCCC;
    tick();
    HOST_WE_I = 1'b0;
    repeat (4) tick();
    EN_I   = 1'b0;
    MODE_I = 1'b0;
    tick();
`else
    // Without the stream feature, stream mode stays in IDLE and host pushes go nowhere.
    EN_I         = 1'b1;
    MODE_I       = 1'b1;
    HOST_WE_I    = 1'b1;
    HOST_WDATA_I = 32'hFFFF;
    repeat (3) tick();
    LOAD_I = 1'b1;
    tick();
    LOAD_I    = 1'b0;
    HOST_WE_I = 1'b0;
    check("nostream_full", {31'd0, HOST_FULL_O}, '0);
    check("nostream_wr_ptr", {26'd0, WR_PTR_O}, '0);
    host_rd(6'd0, 32'h77, "nostream_idle_rd");
    EN_I   = 1'b0;
    MODE_I = 1'b0;
    tick();
`endif

    repeat (3) tick();
    check("exp_queue_empty", exp_q.size(), '0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
